// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_SUM_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sum_if.sv
// Serial line plus received-byte/status bundle for uart_rx_sum.
interface uart_rx_sum_if;
  import uart_pkg::*;

  logic                      i_serial;
  logic [UART_DATA_BITS-1:0] o_data;
  logic                      o_valid;
  logic                      o_frame_err;
  logic                      o_idle;
  logic [UART_SUM_W-1:0]     o_sum;

  // master: the receiver; slave: whoever drives the line and consumes bytes
  modport master (
    input  i_serial,
    output o_data, o_valid, o_frame_err, o_idle, o_sum
  );

  modport slave (
    output i_serial,
    input  o_data, o_valid, o_frame_err, o_idle, o_sum
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_sum.sv
// 8N1 UART receiver with a running 32-bit checksum of accepted bytes,
// start-glitch rejection and framing-error detection.
module uart_rx_sum
  import uart_pkg::*;
#(
  parameter int unsigned           cycles_per_bit = 3,
  parameter logic [UART_SUM_W-1:0] sum_init       = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_sum_if.master rx
);

  localparam logic [15:0] HALF   = 16'(cycles_per_bit / 2);
  localparam logic [15:0] CPB_M1 = 16'(cycles_per_bit - 1);

  logic                      s;
  rx_state_t                 state_q, state_d;
  logic [15:0]               cyc_q, cyc_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      pend_q, pend_d;
  logic                      err_q, err_d;
  logic                      valid_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic [UART_SUM_W-1:0]     sum_q;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx.i_serial),
    .q     (s)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pend_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = START;
          cyc_d   = '0;
        end
      end
      START: begin
        // sample near the centre of the start bit; high here is a glitch
        if (cyc_q == HALF - 16'd1) begin
          cyc_d = '0;
          bit_d = '0;
          state_d = s ? IDLE : DATA;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      DATA: begin
        if (cyc_q == CPB_M1) begin
          cyc_d          = '0;
          shift_d[bit_q] = s;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      STOP: begin
        // return to IDLE at the stop sample so a back-to-back start is caught;
        // the byte itself is published one cycle later via pend_q
        if (cyc_q == CPB_M1) begin
          cyc_d = '0;
          if (s) begin
            pend_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      BREAK: begin
        if (s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sum_q   <= sum_init;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      valid_q <= pend_q;
      if (pend_q) begin
        data_q <= shift_q;
        sum_q  <= sum_q + {{(UART_SUM_W-UART_DATA_BITS){1'b0}}, shift_q};
      end
    end
  end

  assign rx.o_data      = data_q;
  assign rx.o_valid     = valid_q;
  assign rx.o_frame_err = err_q;
  assign rx.o_idle      = (state_q == IDLE);
  assign rx.o_sum       = sum_q;

endmodule

// File: tb/tb_uart_rx_sum.sv
// Directed bench for uart_rx_sum: byte scoreboard, latency, glitch, framing,
// mid-frame reset and checksum wrap.
module tb_uart_rx_sum;
  import uart_pkg::*;

  localparam int CPB  = 3;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  typedef struct {
    logic [7:0]  d;
    logic [31:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_sum_if bus ();
  uart_rx_sum_if bus2 ();

  uart_rx_sum #(.cycles_per_bit(CPB), .sum_init(32'h0)) dut (
    .clk (clk), .rst_n (rst_n), .rx (bus.master)
  );

  uart_rx_sum #(.cycles_per_bit(CPB), .sum_init(32'hFFFF_FFF0)) dut2 (
    .clk (clk), .rst_n (rst_n), .rx (bus2.master)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int vcnt = 0, ecnt = 0, both = 0, v2cnt = 0;
  int vcyc[$];
  exp_t q[$];
  exp_t e;
  logic [31:0] model_sum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_valid) begin
      vcnt++;
      vcyc.push_back(cyc);
      if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("sb_data", {24'h0, bus.o_data}, {24'h0, e.d});
        chk("sb_sum", bus.o_sum, e.s);
      end
    end
    if (bus.o_frame_err) ecnt++;
    if (bus.o_valid && bus.o_frame_err) both++;
    if (bus2.o_valid) v2cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input bit sel, input logic v);
    if (sel) bus2.i_serial = v;
    else     bus.i_serial  = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stop);
    if (!sel && stop) begin
      model_sum = model_sum + {24'h0, b};
      q.push_back('{b, model_sum});
    end
    line(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      line(sel, b[i]);
      tick(CPB);
    end
    line(sel, stop);
    tick(CPB);
  endtask

  task automatic do_reset();
    bus.i_serial  = 1'b1;
    bus2.i_serial = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_sum = 32'h0;
    q.delete();
    tick(2);
  endtask

  int t0, bv, be, bs, b2;

  initial begin
    bus.i_serial  = 1'b1;
    bus2.i_serial = 1'b1;
    model_sum = 32'h0;
    rst_n = 1'b0;
    tick(3);
    chk("rst_data", {24'h0, bus.o_data}, 32'h0);
    chk("rst_valid", {31'h0, bus.o_valid}, 32'h0);
    chk("rst_ferr", {31'h0, bus.o_frame_err}, 32'h0);
    chk("rst_idle", {31'h0, bus.o_idle}, 32'h1);
    chk("rst_sum", bus.o_sum, 32'h0);
    chk("rst_sum_init", bus2.o_sum, 32'hFFFF_FFF0);
    rst_n = 1'b1;
    tick(2);

    // single 'H'; +1 because the line is driven one cycle before it is registered
    bv = vcnt; be = ecnt;
    t0 = cyc;
    send(1'b0, 8'h48, 1'b1);
    tick(10);
    chk("h_count", vcnt - bv, 1);
    chk("h_latency", vcyc[vcyc.size()-1] - t0, LAT + 1);
    chk("h_data", {24'h0, bus.o_data}, 32'h48);
    chk("h_sum", bus.o_sum, 32'h48);
    chk("h_ferr", ecnt - be, 0);
    chk("h_idle", {31'h0, bus.o_idle}, 32'h1);

    // "Hi" back to back
    do_reset();
    bv = vcnt;
    send(1'b0, 8'h48, 1'b1);
    send(1'b0, 8'h69, 1'b1);
    tick(10);
    chk("hi_count", vcnt - bv, 2);
    chk("hi_spacing", vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2], 30);
    chk("hi_data", {24'h0, bus.o_data}, 32'h69);
    chk("hi_sum", bus.o_sum, 32'hB1);

    // one-cycle low glitch while idle
    bv = vcnt; be = ecnt; bs = bus.o_sum;
    line(1'b0, 1'b0);
    tick(1);
    line(1'b0, 1'b1);
    tick(2);
    chk("gl_busy", {31'h0, bus.o_idle}, 32'h0);
    tick(1);
    chk("gl_idle", {31'h0, bus.o_idle}, 32'h1);
    tick(20);
    chk("gl_valid", vcnt - bv, 0);
    chk("gl_ferr", ecnt - be, 0);
    chk("gl_sum", bus.o_sum, bs);

    // framing error, line held low, then a good byte
    do_reset();
    bv = vcnt; be = ecnt;
    send(1'b0, 8'h55, 1'b0);
    tick(20);
    chk("fe_pulses", ecnt - be, 1);
    chk("fe_break", {31'h0, bus.o_idle}, 32'h0);
    line(1'b0, 1'b1);
    tick(5);
    send(1'b0, 8'h01, 1'b1);
    tick(10);
    chk("fe_ferr", ecnt - be, 1);
    chk("fe_valid", vcnt - bv, 1);
    chk("fe_sum", bus.o_sum, 32'h01);

    // reset during bit 4 of 0xFF, then 0x0A
    do_reset();
    bv = vcnt; be = ecnt;
    line(1'b0, 1'b0);
    tick(CPB);
    line(1'b0, 1'b1);
    tick(4 * CPB + 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    model_sum = 32'h0;
    q.delete();
    chk("ab_idle", {31'h0, bus.o_idle}, 32'h1);
    tick(5 * CPB);
    chk("ab_valid", vcnt - bv, 0);
    chk("ab_ferr", ecnt - be, 0);
    send(1'b0, 8'h0A, 1'b1);
    tick(10);
    chk("ab_count", vcnt - bv, 1);
    chk("ab_data", {24'h0, bus.o_data}, 32'h0A);
    chk("ab_sum", bus.o_sum, 32'h0A);

    // checksum wrap on the second instance
    b2 = v2cnt;
    send(1'b1, 8'h20, 1'b1);
    tick(10);
    chk("wr_count", v2cnt - b2, 1);
    chk("wr_data", {24'h0, bus2.o_data}, 32'h20);
    chk("wr_sum", bus2.o_sum, 32'h0000_0010);

    chk("no_overlap", both, 0);
    chk("sb_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
